// File: rtl/laser_slot_scheduler.sv
// Round-robin launch arbiter for a pool of laser engines, with tick-based cooldown between shots.
// Optional held-fire repeat is enabled by defining LASER_SCHED_AUTOFIRE_EN.
module laser_slot_scheduler #(
    parameter int NUM_SLOTS      = 3,
    parameter int COOLDOWN_TICKS = 20,
    parameter int CD_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fire,
    input  logic [9:0]           gunPosition,
    input  logic [NUM_SLOTS-1:0] slotDone,
    output logic [NUM_SLOTS-1:0] launch,
    output logic [9:0]           launchX,
    output logic [NUM_SLOTS-1:0] slotBusy,
    output logic                 fireDenied,
    output logic [15:0]          shotsFired
);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [NUM_SLOTS-1:0] r_launch;
    logic [NUM_SLOTS-1:0] r_busy;
    logic [9:0]           r_launch_x;
    logic                 r_denied;
    logic                 r_fire_q;
    logic [15:0]          r_shots;
    logic [CD_WIDTH-1:0]  r_cd;
    logic [PTR_W-1:0]     r_ptr;

    logic                 w_found_hi;
    logic                 w_found_lo;
    logic [PTR_W-1:0]     w_idx_hi;
    logic [PTR_W-1:0]     w_idx_lo;
    logic                 w_found;
    logic [PTR_W-1:0]     w_sel_idx;
    logic [NUM_SLOTS-1:0] w_sel_onehot;
    logic [PTR_W-1:0]     w_ptr_next;
    logic                 w_cd_zero;
    logic                 w_rise;
    logic                 w_req;
    logic                 w_grant;
    logic                 w_deny;

    // Lowest free slot at or above the pointer wins; otherwise wrap to the lowest free slot below it.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_idx_hi   = '0;
        w_idx_lo   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                if (PTR_W'(i) >= r_ptr) begin
                    w_found_hi = 1'b1;
                    w_idx_hi   = PTR_W'(i);
                end else begin
                    w_found_lo = 1'b1;
                    w_idx_lo   = PTR_W'(i);
                end
            end
        end
        w_found   = w_found_hi | w_found_lo;
        w_sel_idx = w_found_hi ? w_idx_hi : w_idx_lo;
    end

    assign w_sel_onehot = NUM_SLOTS'(1) << w_sel_idx;
    assign w_ptr_next   = (w_sel_idx == PTR_W'(NUM_SLOTS - 1)) ? '0 : w_sel_idx + 1'b1;
    assign w_cd_zero    = (r_cd == '0);
    assign w_rise       = fire & ~r_fire_q;

`ifdef LASER_SCHED_AUTOFIRE_EN
    assign w_req = w_rise | (fire & w_cd_zero & w_found);
`else
    assign w_req = w_rise;
`endif

    assign w_grant = w_req & w_cd_zero & w_found;
    // Held-fire retries never report a denial; only a fresh press does.
    assign w_deny  = w_rise & ~w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_launch   <= '0;
            r_launch_x <= '0;
            r_busy     <= '0;
            r_denied   <= 1'b0;
            r_shots    <= '0;
            r_cd       <= '0;
            r_ptr      <= '0;
            r_fire_q   <= 1'b1;
        end else begin
            r_fire_q <= fire;
            r_denied <= w_deny;
            r_launch <= w_grant ? w_sel_onehot : '0;
            r_busy   <= (r_busy & ~slotDone) | (w_grant ? w_sel_onehot : '0);
            if (w_grant) begin
                r_launch_x <= gunPosition;
                r_ptr      <= w_ptr_next;
                r_cd       <= CD_WIDTH'(COOLDOWN_TICKS);
                if (r_shots != 16'hFFFF) begin
                    r_shots <= r_shots + 16'd1;
                end
            end else if (enable && !w_cd_zero) begin
                r_cd <= r_cd - 1'b1;
            end
        end
    end

    assign launch     = r_launch;
    assign launchX    = r_launch_x;
    assign slotBusy   = r_busy;
    assign fireDenied = r_denied;
    assign shotsFired = r_shots;

endmodule

// File: tb/tb_laser_slot_scheduler.sv
// Directed bench for laser_slot_scheduler: one instance with a 4-tick cooldown, one with none,
// and (when LASER_SCHED_AUTOFIRE_EN is defined) one with a 2-tick cooldown for held-fire repeat.
module tb_laser_slot_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] gun;

    logic       fire_a, fire_b;
    logic [2:0] done_a, done_b;
    logic [2:0] launch_a, busy_a, launch_b, busy_b;
    logic [9:0] lx_a, lx_b;
    logic       den_a, den_b;
    logic [15:0] shots_a, shots_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    laser_slot_scheduler #(.NUM_SLOTS(3), .COOLDOWN_TICKS(4), .CD_WIDTH(8)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .fire(fire_a), .gunPosition(gun),
        .slotDone(done_a), .launch(launch_a), .launchX(lx_a), .slotBusy(busy_a),
        .fireDenied(den_a), .shotsFired(shots_a)
    );

    laser_slot_scheduler #(.NUM_SLOTS(3), .COOLDOWN_TICKS(0), .CD_WIDTH(8)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .fire(fire_b), .gunPosition(gun),
        .slotDone(done_b), .launch(launch_b), .launchX(lx_b), .slotBusy(busy_b),
        .fireDenied(den_b), .shotsFired(shots_b)
    );

`ifdef LASER_SCHED_AUTOFIRE_EN
    logic       fire_c;
    logic [2:0] done_c;
    logic [2:0] launch_c, busy_c;
    logic [9:0] lx_c;
    logic       den_c;
    logic [15:0] shots_c;

    laser_slot_scheduler #(.NUM_SLOTS(3), .COOLDOWN_TICKS(2), .CD_WIDTH(8)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .fire(fire_c), .gunPosition(gun),
        .slotDone(done_c), .launch(launch_c), .launchX(lx_c), .slotBusy(busy_c),
        .fireDenied(den_c), .shotsFired(shots_c)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        gun    = 10'd0;
        fire_a = 1'b1;
        fire_b = 1'b1;
        done_a = '0;
        done_b = '0;
`ifdef LASER_SCHED_AUTOFIRE_EN
        fire_c = 1'b0;
        done_c = '0;
`endif
        tick();
        tick();
        chk("rst_launch", launch_a, 3'b000);
        chk("rst_launchX", lx_a, 10'd0);
        chk("rst_busy", busy_a, 3'b000);
        chk("rst_denied", den_a, 1'b0);
        chk("rst_shots", shots_a, 16'd0);

        // Button held through reset: no shot after reset drops
        reset = 1'b0;
        tick();
        chk("held_no_launch", launch_a, 3'b000);
        chk("held_no_deny", den_a, 1'b0);
        fire_a = 1'b0;
        fire_b = 1'b0;
        tick();
        tick();
        tick();

        // First press, gun at 320
        gun    = 10'd320;
        fire_a = 1'b1;
        tick();
        chk("t1_launch", launch_a, 3'b001);
        chk("t1_launchX", lx_a, 10'd320);
        chk("t1_busy", busy_a, 3'b001);
        chk("t1_shots", shots_a, 16'd1);

        // Cooldown 4: second press inside the window is denied
        fire_a = 1'b0;
        gun    = 10'd100;
        tick();
        chk("t2_strobe_1cyc", launch_a, 3'b000);
        chk("t2_x_held", lx_a, 10'd320);
        fire_a = 1'b1;
        tick();
        chk("t2_denied", den_a, 1'b1);
        chk("t2_no_launch", launch_a, 3'b000);
        chk("t2_shots", shots_a, 16'd1);
        fire_a = 1'b0;
        tick();
        chk("t2_deny_1cyc", den_a, 1'b0);

        // Cooldown frozen while enable is low (one tick left)
        enable = 1'b0;
        tick();
        tick();
        fire_a = 1'b1;
        tick();
        chk("t2_frozen_deny", den_a, 1'b1);
        chk("t2_frozen_nolaunch", launch_a, 3'b000);
        fire_a = 1'b0;
        enable = 1'b1;
        tick();
        chk("t2_quiet", den_a, 1'b0);
        gun    = 10'd200;
        fire_a = 1'b1;
        tick();
        chk("t2_launch2", launch_a, 3'b010);
        chk("t2_launchX2", lx_a, 10'd200);
        chk("t2_busy2", busy_a, 3'b011);
        chk("t2_shots2", shots_a, 16'd2);

        // Free slot 1, then fill slot 2 to reach busy=101
        fire_a = 1'b0;
        done_a = 3'b010;
        tick();
        chk("t5_done_frees", busy_a, 3'b001);
        done_a = 3'b000;
        tick();
        tick();
        tick();
        gun    = 10'd5;
        fire_a = 1'b1;
        tick();
        chk("t5_launch3", launch_a, 3'b100);
        chk("t5_busy101", busy_a, 3'b101);
        chk("t5_shots3", shots_a, 16'd3);

        // Reset mid-flight with cooldown loaded
        fire_a = 1'b0;
        reset  = 1'b1;
        tick();
        chk("t5_rst_busy", busy_a, 3'b000);
        chk("t5_rst_shots", shots_a, 16'd0);
        chk("t5_rst_launchX", lx_a, 10'd0);
        reset = 1'b0;
        tick();
        gun    = 10'd77;
        fire_a = 1'b1;
        tick();
        chk("t5_post_launch", launch_a, 3'b001);
        chk("t5_post_x", lx_a, 10'd77);
        chk("t5_post_shots", shots_a, 16'd1);
        fire_a = 1'b0;
        tick();

        // No cooldown: three quick presses fill the pool, fourth is denied
        fire_b = 1'b1;
        tick();
        chk("t3_l0", launch_b, 3'b001);
        fire_b = 1'b0;
        tick();
        fire_b = 1'b1;
        tick();
        chk("t3_l1", launch_b, 3'b010);
        fire_b = 1'b0;
        tick();
        fire_b = 1'b1;
        tick();
        chk("t3_l2", launch_b, 3'b100);
        chk("t3_busy_full", busy_b, 3'b111);
        fire_b = 1'b0;
        tick();
        fire_b = 1'b1;
        tick();
        chk("t3_denied", den_b, 1'b1);
        chk("t3_nolaunch", launch_b, 3'b000);
        chk("t3_busy", busy_b, 3'b111);
        chk("t3_shots", shots_b, 16'd3);
        fire_b = 1'b0;
        tick();

        // Done and press in the same cycle: freed slot is not yet grantable
        done_b = 3'b010;
        fire_b = 1'b1;
        tick();
        chk("t4_denied", den_b, 1'b1);
        chk("t4_nolaunch", launch_b, 3'b000);
        chk("t4_busy", busy_b, 3'b101);
        done_b = 3'b000;
        fire_b = 1'b0;
        tick();
        fire_b = 1'b1;
        tick();
        chk("t4_launch", launch_b, 3'b010);
        chk("t4_busy_full", busy_b, 3'b111);
        chk("t4_shots", shots_b, 16'd4);

        // Pointer now at 2 with slot 2 busy: scan wraps to slot 0
        fire_b = 1'b0;
        done_b = 3'b001;
        tick();
        chk("wrap_freed", busy_b, 3'b110);
        done_b = 3'b000;
        fire_b = 1'b1;
        tick();
        chk("wrap_launch", launch_b, 3'b001);
        chk("wrap_deny_excl", den_b, 1'b0);
        fire_b = 1'b0;
        tick();

`ifdef LASER_SCHED_AUTOFIRE_EN
        // Held fire, cooldown 2: grants every third cycle, then stops silently
        fire_c = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            case (k)
                1:       chk("af_launch0", launch_c, 3'b001);
                4:       chk("af_launch1", launch_c, 3'b010);
                7:       chk("af_launch2", launch_c, 3'b100);
                default: chk("af_idle", launch_c, 3'b000);
            endcase
            chk("af_no_deny", den_c, 1'b0);
        end
        chk("af_busy", busy_c, 3'b111);
        chk("af_shots", shots_c, 16'd3);
        fire_c = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
